// File: rtl/pkt_dvdr_tx_pkg.sv
// ---------------------------------------------------------------------------
// pkt_dvdr_tx_pkg
// Shared definitions for the packet-divider transmit framer:
//   - tx_state_e      : framer state encoding
//   - *_CODE_DEF      : default SOP / EOP / PAD byte values
//   - calc_pad_len()  : number of pad bytes needed to reach the minimum length
//   - parity_fold()   : one step of the running XOR parity over a frame byte
// ---------------------------------------------------------------------------
package pkt_dvdr_tx_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        SOP  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        PAD  = 3'd4,
        PAR  = 3'd5,
        EOP  = 3'd6
    } tx_state_e;

    localparam logic [7:0] SOP_CODE_DEF = 8'hA5;
    localparam logic [7:0] EOP_CODE_DEF = 8'h5A;
    localparam logic [7:0] PAD_BYTE_DEF = 8'h00;

    // Pad bytes required so that payload + padding reaches min_payload.
    function automatic int calc_pad_len(input int len, input int min_payload);
        int pad_v;
        if (len < min_payload) begin
            pad_v = min_payload - len;
        end else begin
            pad_v = 0;
        end
        return pad_v;
    endfunction

    // Running parity is a plain byte-wise XOR; kept as a function so the
    // framer and any future checker share one definition.
    function automatic logic [31:0] parity_fold(input logic [31:0] acc, input logic [31:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/pkt_dvdr_tx_buf.sv
// ---------------------------------------------------------------------------
// pkt_dvdr_tx_buf
// DEPTH x DATA_W simple dual-port payload buffer.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears the read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates on the next edge when set
//   rd_addr  in   read address
//   rd_data  out  registered read data (one cycle after rd_addr/rd_en)
// ---------------------------------------------------------------------------
module pkt_dvdr_tx_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Payload storage: synchronous write, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pkt_dvdr_tx_framer.sv
// ---------------------------------------------------------------------------
// pkt_dvdr_tx_framer
// Buffers one payload packet from a valid/ready byte stream and emits it as
//   SOP | LEN | D1..Dn | PAD.. | PARITY | EOP
// with downstream backpressure, minimum-length padding and overflow
// truncation at DEPTH bytes.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   payload byte valid
//   in_data   in   payload byte
//   in_last   in   final payload byte of the packet
//   in_ready  out  framer accepts a payload byte (only while loading)
//   tx_ready  in   downstream accepts a frame byte this cycle
//   tx_en     out  tx_data holds a valid frame byte (registered)
//   tx_data   out  frame byte (registered, holds when nothing is issued)
//   busy      out  frame transmission in progress
//   ovf_err   out  one-cycle pulse: packet truncated at DEPTH bytes
// ---------------------------------------------------------------------------
module pkt_dvdr_tx_framer
    import pkt_dvdr_tx_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 64,
    parameter int                MIN_PAYLOAD = 4,
    parameter logic [DATA_W-1:0] SOP_CODE    = DATA_W'(SOP_CODE_DEF),
    parameter logic [DATA_W-1:0] EOP_CODE    = DATA_W'(EOP_CODE_DEF),
    parameter logic [DATA_W-1:0] PAD_BYTE    = DATA_W'(PAD_BYTE_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              tx_ready,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              ovf_err
);

    // Counters must reach DEPTH itself (LEN = DEPTH on overflow).
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tx_state_e         state_r, state_nxt_s;
    logic [CNT_W-1:0]  wr_cnt_r, wr_cnt_nxt_s;
    logic [CNT_W-1:0]  rd_cnt_r, rd_cnt_nxt_s;
    logic [CNT_W-1:0]  len_r, len_nxt_s;
    logic [CNT_W-1:0]  pad_rem_r, pad_rem_nxt_s;
    logic [DATA_W-1:0] parity_r, parity_nxt_s;
    logic              tx_en_r, tx_en_nxt_s;
    logic [DATA_W-1:0] tx_data_r, tx_data_nxt_s;
    logic              ovf_r, ovf_nxt_s;
    logic              in_ready_r;
    logic              busy_r;

    logic              accept_s;
    logic              at_full_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [DATA_W-1:0] rd_data_s;

    assign accept_s  = in_valid && in_ready_r;
    assign at_full_s = (wr_cnt_r == CNT_W'(DEPTH - 1));

    // Prefetch: the buffer is addressed with the next read count, so its
    // registered output always matches rd_cnt_r while in DATA. Reading starts
    // in LEN so byte 0 is ready on the first DATA cycle.
    assign rd_en_s = (state_r == LEN) || (state_r == DATA);

    pkt_dvdr_tx_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_addr (wr_cnt_r[AW-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_cnt_nxt_s[AW-1:0]),
        .rd_data (rd_data_s)
    );

    // Next-state, counter, parity and output-byte selection.
    always_comb begin
        state_nxt_s   = state_r;
        wr_cnt_nxt_s  = wr_cnt_r;
        rd_cnt_nxt_s  = rd_cnt_r;
        len_nxt_s     = len_r;
        pad_rem_nxt_s = pad_rem_r;
        parity_nxt_s  = parity_r;
        tx_en_nxt_s   = 1'b0;
        tx_data_nxt_s = tx_data_r;
        ovf_nxt_s     = 1'b0;
        wr_en_s       = 1'b0;

        case (state_r)
            LOAD: begin
                if (accept_s) begin
                    wr_en_s      = 1'b1;
                    wr_cnt_nxt_s = wr_cnt_r + CNT_W'(1);
                    // The DEPTH-th byte closes the packet even without in_last.
                    if (in_last || at_full_s) begin
                        len_nxt_s     = wr_cnt_r + CNT_W'(1);
                        pad_rem_nxt_s = CNT_W'(calc_pad_len(int'(wr_cnt_r) + 1, MIN_PAYLOAD));
                        ovf_nxt_s     = !in_last;
                        state_nxt_s   = SOP;
                    end else begin
                        state_nxt_s   = LOAD;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end

            SOP: begin
                if (tx_ready) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = SOP_CODE;
                    state_nxt_s   = LEN;
                end else begin
                    state_nxt_s   = SOP;
                end
            end

            LEN: begin
                if (tx_ready) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = DATA_W'(len_r);
                    parity_nxt_s  = DATA_W'(len_r);
                    state_nxt_s   = DATA;
                end else begin
                    state_nxt_s   = LEN;
                end
            end

            DATA: begin
                if (tx_ready) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = rd_data_s;
                    parity_nxt_s  = DATA_W'(parity_fold(32'(parity_r), 32'(rd_data_s)));
                    rd_cnt_nxt_s  = rd_cnt_r + CNT_W'(1);
                    if (rd_cnt_r == (len_r - CNT_W'(1))) begin
                        if (pad_rem_r != {CNT_W{1'b0}}) begin
                            state_nxt_s = PAD;
                        end else begin
                            state_nxt_s = PAR;
                        end
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end

            PAD: begin
                if (tx_ready) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = PAD_BYTE;
                    parity_nxt_s  = DATA_W'(parity_fold(32'(parity_r), 32'(PAD_BYTE)));
                    pad_rem_nxt_s = pad_rem_r - CNT_W'(1);
                    if (pad_rem_r == CNT_W'(1)) begin
                        state_nxt_s = PAR;
                    end else begin
                        state_nxt_s = PAD;
                    end
                end else begin
                    state_nxt_s = PAD;
                end
            end

            PAR: begin
                if (tx_ready) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = parity_r;
                    state_nxt_s   = EOP;
                end else begin
                    state_nxt_s   = PAR;
                end
            end

            EOP: begin
                if (tx_ready) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = EOP_CODE;
                    wr_cnt_nxt_s  = {CNT_W{1'b0}};
                    rd_cnt_nxt_s  = {CNT_W{1'b0}};
                    len_nxt_s     = {CNT_W{1'b0}};
                    pad_rem_nxt_s = {CNT_W{1'b0}};
                    parity_nxt_s  = {DATA_W{1'b0}};
                    state_nxt_s   = LOAD;
                end else begin
                    state_nxt_s   = EOP;
                end
            end

            default: begin
                state_nxt_s = LOAD;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers and registered outputs; in_ready/busy are decoded
    // from the next state so they line up with state_r without a glitchy decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_r   <= {CNT_W{1'b0}};
            rd_cnt_r   <= {CNT_W{1'b0}};
            len_r      <= {CNT_W{1'b0}};
            pad_rem_r  <= {CNT_W{1'b0}};
            parity_r   <= {DATA_W{1'b0}};
            tx_en_r    <= 1'b0;
            tx_data_r  <= {DATA_W{1'b0}};
            ovf_r      <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            wr_cnt_r   <= wr_cnt_nxt_s;
            rd_cnt_r   <= rd_cnt_nxt_s;
            len_r      <= len_nxt_s;
            pad_rem_r  <= pad_rem_nxt_s;
            parity_r   <= parity_nxt_s;
            tx_en_r    <= tx_en_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            ovf_r      <= ovf_nxt_s;
            in_ready_r <= (state_nxt_s == LOAD);
            busy_r     <= (state_nxt_s != LOAD);
        end
    end

    assign in_ready = in_ready_r;
    assign tx_en    = tx_en_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign ovf_err  = ovf_r;

endmodule

// File: tb/tb_pkt_dvdr_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_pkt_dvdr_tx_framer
// Directed bench for pkt_dvdr_tx_framer (default parameters). A frame-level
// model turns each accepted packet into its expected byte sequence; a monitor
// pops and compares every emitted byte. Hand-computed LEN/parity literals pin
// the model.
// ---------------------------------------------------------------------------
module tb_pkt_dvdr_tx_framer;

    localparam int DEPTH = 64;
    localparam int MINP  = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       tx_ready;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       busy;
    logic       ovf_err;

    pkt_dvdr_tx_framer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .tx_ready (tx_ready),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .busy     (busy),
        .ovf_err  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         first;
        bit         is_len;
        bit         is_par;
        bit         last;
    } fb_t;

    fb_t        exp_q[$];
    logic [7:0] cur[$];
    logic [7:0] seen_len[$];
    logic [7:0] seen_par[$];

    int  checks = 0;
    int  failures = 0;
    int  ovf_seen = 0;
    int  cyc = 0;
    int  eop_cyc = -1;
    int  last_acc_cyc = -1;
    bit  run = 0;
    logic rdy_edge = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a complete packet becomes SOP, LEN, payload, pad, parity, EOP.
    function automatic void build_frame();
        fb_t e;
        int  n;
        int  padn;
        logic [7:0] p;
        n = cur.size();
        padn = (n < MINP) ? (MINP - n) : 0;
        p = 8'(n);
        e = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}; exp_q.push_back(e);
        e = '{8'(n), 1'b0, 1'b1, 1'b0, 1'b0}; exp_q.push_back(e);
        foreach (cur[i]) begin
            e = '{cur[i], 1'b0, 1'b0, 1'b0, 1'b0}; exp_q.push_back(e);
            p = p ^ cur[i];
        end
        for (int i = 0; i < padn; i++) begin
            e = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; exp_q.push_back(e);
        end
        e = '{p, 1'b0, 1'b0, 1'b1, 1'b0}; exp_q.push_back(e);
        e = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1}; exp_q.push_back(e);
    endfunction

    function automatic logic [8:0] pop_len();
        if (seen_len.size() == 0) return 9'h1FF;
        return {1'b0, seen_len.pop_front()};
    endfunction

    function automatic logic [8:0] pop_par();
        if (seen_par.size() == 0) return 9'h1FF;
        return {1'b0, seen_par.pop_front()};
    endfunction

    // Cycle count and tx_ready as seen at each active edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_edge <= tx_ready;
    end

    // Monitor: every emitted byte must be the next expected frame byte.
    always @(negedge clk) begin
        if (rst_n && run) begin
            chk("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, ~busy});
            if (ovf_err) ovf_seen++;
            if (tx_en) begin
                chk("tx_en_without_ready", {31'd0, rdy_edge}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    fb_t e;
                    e = exp_q.pop_front();
                    chk("frame_byte", {24'd0, tx_data}, {24'd0, e.b});
                    if (e.first) chk("in_ready_at_sop", {31'd0, in_ready}, 32'd0);
                    if (e.last) begin
                        chk("in_ready_after_eop", {31'd0, in_ready}, 32'd1);
                        eop_cyc = cyc;
                    end
                    if (e.is_len) seen_len.push_back(tx_data);
                    if (e.is_par) seen_par.push_back(tx_data);
                end
            end
        end
    end

    // Offer one byte (called at a negedge); returns at the negedge after it transfers.
    task automatic push(input logic [7:0] d, input bit last);
        int w;
        bit closing;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            chk("in_ready_timeout", 32'(w), 32'd0);
        end else begin
            @(negedge clk);
            last_acc_cyc = cyc;
            cur.push_back(d);
            closing = last || (cur.size() == DEPTH);
            chk("ovf_pulse", {31'd0, ovf_err}, {31'd0, closing && !last});
            if (closing) begin
                build_frame();
                cur.delete();
            end
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", {31'd0, (w < 400)}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] t1_exp [9];
        t1_exp = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h14, 8'h5A};
        rst_n = 1'b0; tx_ready = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;

        // Reset state
        #12;
        chk("rst_tx_en",   {31'd0, tx_en},   32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_ovf",     {31'd0, ovf_err}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        run = 1;

        // 1: five bytes, contiguous nine-byte frame, SOP one edge after last accept
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0); push(8'h55, 1);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t1_tx_en", {31'd0, tx_en}, 32'd1);
            chk("t1_byte",  {24'd0, tx_data}, {24'd0, t1_exp[i]});
        end
        @(negedge clk);
        chk("t1_tx_en_end", {31'd0, tx_en}, 32'd0);
        wait_idle();
        chk("t1_len", 32'(pop_len()), 32'h05);
        chk("t1_par", 32'(pop_par()), 32'h14);

        // 2: single byte, padded to four
        push(8'h7E, 1); in_valid = 1'b0;
        wait_idle();
        chk("t2_len", 32'(pop_len()), 32'h01);
        chk("t2_par", 32'(pop_par()), 32'h7F);

        // 3: three-cycle stall right after LEN
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 1);
        in_valid = 1'b0;
        @(negedge clk);          // SOP shown
        @(negedge clk);          // LEN shown
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_tx_en", {31'd0, tx_en}, 32'd0);
            chk("t3_stall_hold",  {24'd0, tx_data}, 32'h04);
        end
        tx_ready = 1'b1;
        wait_idle();
        chk("t3_len", 32'(pop_len()), 32'h04);
        chk("t3_par", 32'(pop_par()), 32'h40);

        // 4: 66 bytes, only the last flagged -> 64-byte truncated frame then 2-byte frame
        for (int i = 1; i <= 66; i++) push(8'(i), (i == 66));
        in_valid = 1'b0;
        wait_idle();
        chk("t4_len_a", 32'(pop_len()), 32'h40);
        chk("t4_par_a", 32'(pop_par()), 32'h00);
        chk("t4_len_b", 32'(pop_len()), 32'h02);
        chk("t4_par_b", 32'(pop_par()), 32'h01);
        chk("t4_ovf_count", 32'(ovf_seen), 32'd1);

        // 5: reset in the middle of DATA, then a clean frame
        for (int i = 1; i <= 8; i++) push(8'(i), (i == 8));
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete(); cur.delete(); seen_len.delete(); seen_par.delete();
        #2;
        chk("t5_rst_tx_en", {31'd0, tx_en}, 32'd0);
        chk("t5_rst_busy",  {31'd0, busy},  32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_tx_en",    {31'd0, tx_en},    32'd0);
        push(8'hAA, 1); in_valid = 1'b0;
        wait_idle();
        chk("t5_len", 32'(pop_len()), 32'h01);
        chk("t5_par", 32'(pop_par()), 32'hAB);

        // 6: back-to-back packets with in_valid held high
        for (int i = 1; i <= 5; i++) push(8'(i), (i == 5));
        push(8'h10, 0);
        chk("t6_b2b_load", 32'(last_acc_cyc), 32'(eop_cyc + 1));
        push(8'h20, 1);
        in_valid = 1'b0;
        wait_idle();
        chk("t6_len_a", 32'(pop_len()), 32'h05);
        chk("t6_par_a", 32'(pop_par()), 32'h04);
        chk("t6_len_b", 32'(pop_len()), 32'h02);
        chk("t6_par_b", 32'(pop_par()), 32'h32);
        chk("final_ovf_count", 32'(ovf_seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
